// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the RV32I pipeline.
// Issues loads/stores on a req/ready data bus, holds the pipeline while an
// access is outstanding, extends load results and resolves the branch.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ALU_result_in,
   input  logic [31:0] reg_read_data2_in,
   input  logic [2:0]  funct3_in,
   input  logic        M_mem_read_in,
   input  logic        M_mem_write_in,
   input  logic        M_branch_in,
   input  logic        ALU_zero_in,
   input  logic [31:0] branch_adder_sum_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] load_data_out,
   output logic        load_valid,
   output logic        mem_stall,
   output logic        misaligned_fault,
   output logic        bus_error,
   output logic        pc_src,
   output logic [31:0] branch_target_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       size_reg;
   logic             unsigned_reg;
   logic [1:0]       addr_lo_reg;
   logic             is_load_reg;

   logic             access;
   logic             is_write;
   logic [1:0]       size;
   logic             uns;
   logic             legal_size;
   logic             misaligned;
   logic             start;
   logic             timeout_hit;
   logic [3:0]       wstrb_next;
   logic [31:0]      wdata_next;
   logic [31:0]      load_ext_next;
   logic [7:0]       sel_byte;
   logic [15:0]      sel_half;
   logic [7:0]       rd_byte [4];

   // A write wins when read and write are both requested.
   assign access   = M_mem_read_in | M_mem_write_in;
   assign is_write = M_mem_write_in;
   assign size     = funct3_in[1:0];
   assign uns      = funct3_in[2];

   // Stores only allow 000/001/010; loads additionally allow 100/101.
   assign legal_size = (size != 2'b11) && !(uns && (is_write || size == 2'b10));
   assign misaligned = ((size == 2'b01) && ALU_result_in[0]) ||
                       ((size == 2'b10) && (ALU_result_in[1:0] != 2'b00));

   assign misaligned_fault = (state_reg == IDLE) && access && (!legal_size || misaligned);
   assign start            = (state_reg == IDLE) && access && legal_size && !misaligned;
   assign mem_stall        = start || (state_reg == BUSY);
   assign timeout_hit      = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   // Branch resolution does not depend on the memory FSM.
   assign pc_src            = M_branch_in & ALU_zero_in;
   assign branch_target_out = branch_adder_sum_in;

   // Split the read word into byte lanes for load selection.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
   end

   // Store lane placement: data replicated across lanes, strobes mark the target bytes.
   always_comb begin
      wstrb_next = 4'b0000;
      wdata_next = 32'h0000_0000;
      if (is_write) begin
         case (size)
            2'b00: begin
               wstrb_next = 4'b0001 << ALU_result_in[1:0];
               wdata_next = {4{reg_read_data2_in[7:0]}};
            end
            2'b01: begin
               wstrb_next = 4'b0011 << ALU_result_in[1:0];
               wdata_next = {2{reg_read_data2_in[15:0]}};
            end
            default: begin
               wstrb_next = 4'b1111;
               wdata_next = reg_read_data2_in;
            end
         endcase
      end
   end

   // Load extraction uses the size/sign and byte offset latched at issue.
   always_comb begin
      sel_byte      = rd_byte[addr_lo_reg];
      sel_half      = addr_lo_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_ext_next = dmem_rdata;
      case (size_reg)
         2'b00:   load_ext_next = unsigned_reg ? {24'h000000, sel_byte}
                                               : {{24{sel_byte[7]}}, sel_byte};
         2'b01:   load_ext_next = unsigned_reg ? {16'h0000, sel_half}
                                               : {{16{sel_half[15]}}, sel_half};
         default: load_ext_next = dmem_rdata;
      endcase
   end

   // Access FSM with registered bus signals, load result and status pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         size_reg      <= 2'b00;
         unsigned_reg  <= 1'b0;
         addr_lo_reg   <= 2'b00;
         is_load_reg   <= 1'b0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= 32'h0000_0000;
         dmem_wdata    <= 32'h0000_0000;
         dmem_wstrb    <= 4'b0000;
         load_data_out <= 32'h0000_0000;
         load_valid    <= 1'b0;
         bus_error     <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         bus_error  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg    <= BUSY;
                  dmem_req     <= 1'b1;
                  dmem_we      <= is_write;
                  dmem_addr    <= {ALU_result_in[31:2], 2'b00};
                  dmem_wdata   <= wdata_next;
                  dmem_wstrb   <= wstrb_next;
                  size_reg     <= size;
                  unsigned_reg <= uns;
                  addr_lo_reg  <= ALU_result_in[1:0];
                  is_load_reg  <= !is_write;
                  cnt_reg      <= '0;
               end
            end
            BUSY: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (dmem_ready) begin
                  dmem_req  <= 1'b0;
                  state_reg <= DONE;
                  if (is_load_reg) begin
                     load_data_out <= load_ext_next;
                     load_valid    <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  dmem_req  <= 1'b0;
                  bus_error <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // EX/MEM advances at the end of this cycle, so the held
               // instruction is never reissued.
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios plus randomized accesses
// checked against a behavioural model of loads, stores and legality.
module tb_mem_access_stage;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ALU_result_in = '0;
   logic [31:0] reg_read_data2_in = '0;
   logic [2:0]  funct3_in = '0;
   logic        M_mem_read_in = 1'b0;
   logic        M_mem_write_in = 1'b0;
   logic        M_branch_in = 1'b0;
   logic        ALU_zero_in = 1'b0;
   logic [31:0] branch_adder_sum_in = '0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic [31:0] load_data_out;
   logic        load_valid;
   logic        mem_stall;
   logic        misaligned_fault;
   logic        bus_error;
   logic        pc_src;
   logic [31:0] branch_target_out;

   int tests_run = 0;
   int tests_failed = 0;

   // observations from one access
   int          obs_req_cnt, obs_req_first, obs_stall_cnt, obs_lv_cnt, obs_lv_cycle;
   int          obs_be_cnt, obs_be_cycle;
   logic        obs_fault0, obs_stall0;
   logic        obs_we;
   logic [31:0] obs_addr, obs_wdata, obs_ld;
   logic [3:0]  obs_wstrb;
   logic [31:0] model_ld;

   mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .ALU_result_in(ALU_result_in), .reg_read_data2_in(reg_read_data2_in),
      .funct3_in(funct3_in), .M_mem_read_in(M_mem_read_in), .M_mem_write_in(M_mem_write_in),
      .M_branch_in(M_branch_in), .ALU_zero_in(ALU_zero_in),
      .branch_adder_sum_in(branch_adder_sum_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .load_data_out(load_data_out), .load_valid(load_valid), .mem_stall(mem_stall),
      .misaligned_fault(misaligned_fault), .bus_error(bus_error),
      .pc_src(pc_src), .branch_target_out(branch_target_out)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural reference model ----------------
   function automatic int m_bytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
      bit ok;
      if (wr) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      return ok && ((int'(a[1:0]) % m_bytes(f3)) == 0);
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * int'(a[1:0]));
      if (m_bytes(f3) == 1) begin
         v = v & 32'hFF;
         if (!f3[2] && v >= 32'd128) v = v - 32'd256;
      end else if (m_bytes(f3) == 2) begin
         v = v & 32'hFFFF;
         if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
      end
      return v;
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
      int s;
      s = ((1 << m_bytes(f3)) - 1) << int'(a[1:0]);
      return 4'(s);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (m_bytes(f3) == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
      if (m_bytes(f3) == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   // ---------------- stimulus driver ----------------
   // Cycle 0 presents the access; ready is returned in cycle k+1 (k<0: never).
   // The access inputs are withdrawn at cycle clear_at.
   task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input int k,
                             input logic [31:0] rdata, input int clear_at);
      obs_req_cnt = 0; obs_req_first = -1; obs_stall_cnt = 0; obs_lv_cnt = 0;
      obs_lv_cycle = -1; obs_be_cnt = 0; obs_be_cycle = -1;
      obs_fault0 = 1'b0; obs_stall0 = 1'b0;
      obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
      for (int c = 0; c <= clear_at + 1; c++) begin
         @(negedge clock);
         if (c == 0) begin
            M_mem_read_in = rd; M_mem_write_in = wr; funct3_in = f3;
            ALU_result_in = a; reg_read_data2_in = d;
         end
         if (c == clear_at) begin
            M_mem_read_in = 1'b0; M_mem_write_in = 1'b0;
         end
         // a ready pulse while idle must be ignored
         dmem_ready = (c == 0) || (k >= 0 && c == k + 1);
         dmem_rdata = (c == 0) ? ~rdata : rdata;
         #1;
         if (c == 0) begin obs_fault0 = misaligned_fault; obs_stall0 = mem_stall; end
         if (dmem_req) begin
            obs_req_cnt++;
            if (obs_req_first < 0) begin
               obs_req_first = c; obs_we = dmem_we; obs_addr = dmem_addr;
               obs_wdata = dmem_wdata; obs_wstrb = dmem_wstrb;
            end
         end
         if (mem_stall) obs_stall_cnt++;
         if (load_valid) begin obs_lv_cnt++; obs_lv_cycle = c; end
         if (bus_error) begin obs_be_cnt++; obs_be_cycle = c; end
      end
      obs_ld = load_data_out;
      @(negedge clock);
      dmem_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", dmem_req); end
      tests_run++; if (dmem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", dmem_we); end
      tests_run++; if (dmem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", dmem_addr); end
      tests_run++; if (dmem_wdata !== 32'h0 || dmem_wstrb !== 4'h0) begin tests_failed++; $display("FAIL reset_wdata_wstrb: got %h/%b want 0/0", dmem_wdata, dmem_wstrb); end
      tests_run++; if (load_data_out !== 32'h0) begin tests_failed++; $display("FAIL reset_load_data: got %h want 0", load_data_out); end
      tests_run++; if (load_valid !== 1'b0 || bus_error !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses: got lv=%b be=%b want 0/0", load_valid, bus_error); end
      tests_run++; if (mem_stall !== 1'b0 || misaligned_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_stall_fault: got %b/%b want 0/0", mem_stall, misaligned_fault); end
      reset = 1'b0;
      model_ld = 32'h0;
      $display("[TB] txn reset done");
   endtask

   task automatic test_lw();
      run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 5);
      model_ld = 32'hDEADBEEF;
      $display("[TB] txn LW addr=00000100 k=2");
      tests_run++; if (obs_req_cnt !== 3 || obs_req_first !== 1) begin tests_failed++; $display("FAIL lw_req: got %0d cycles from %0d want 3 from 1", obs_req_cnt, obs_req_first); end
      tests_run++; if (obs_stall_cnt !== 4 || obs_stall0 !== 1'b1) begin tests_failed++; $display("FAIL lw_stall: got %0d cycles (c0=%b) want 4 (c0=1)", obs_stall_cnt, obs_stall0); end
      tests_run++; if (obs_lv_cnt !== 1 || obs_lv_cycle !== 4) begin tests_failed++; $display("FAIL lw_valid: got %0d pulses at %0d want 1 at 4", obs_lv_cnt, obs_lv_cycle); end
      tests_run++; if (obs_ld !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data: got %h want deadbeef", obs_ld); end
      tests_run++; if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_wstrb !== 4'b0000) begin tests_failed++; $display("FAIL lw_bus: got addr=%h we=%b strb=%b want 00000100/0/0000", obs_addr, obs_we, obs_wstrb); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3s [3];
      logic [31:0] as  [3];
      logic [31:0] exp [3];
      f3s[0] = 3'b000; as[0] = 32'h103; exp[0] = 32'hFFFFFF80;
      f3s[1] = 3'b100; as[1] = 32'h103; exp[1] = 32'h00000080;
      f3s[2] = 3'b101; as[2] = 32'h102; exp[2] = 32'h000080FF;
      for (int i = 0; i < 3; i++) begin
         run_access(1'b1, 1'b0, f3s[i], as[i], 32'h0, 0, 32'h80FF1234, 3);
         model_ld = exp[i];
         $display("[TB] txn load f3=%b addr=%h k=0", f3s[i], as[i]);
         tests_run++; if (obs_ld !== exp[i]) begin tests_failed++; $display("FAIL load_ext_%0d: got %h want %h", i, obs_ld, exp[i]); end
         tests_run++; if (obs_addr !== 32'h100) begin tests_failed++; $display("FAIL load_ext_addr_%0d: got %h want 00000100", i, obs_addr); end
      end
   endtask

   task automatic test_store();
      run_access(1'b0, 1'b1, 3'b001, 32'h206, 32'h0000ABCD, 0, 32'h0, 3);
      $display("[TB] txn SH addr=00000206 k=0");
      tests_run++; if (obs_addr !== 32'h204 || obs_we !== 1'b1) begin tests_failed++; $display("FAIL sh_addr_we: got %h/%b want 00000204/1", obs_addr, obs_we); end
      tests_run++; if (obs_wstrb !== 4'b1100) begin tests_failed++; $display("FAIL sh_wstrb: got %b want 1100", obs_wstrb); end
      tests_run++; if (obs_wdata !== 32'hABCDABCD) begin tests_failed++; $display("FAIL sh_wdata: got %h want abcdabcd", obs_wdata); end
      tests_run++; if (obs_lv_cnt !== 0 || obs_ld !== model_ld) begin tests_failed++; $display("FAIL sh_no_load: got lv=%0d data=%h want 0/%h", obs_lv_cnt, obs_ld, model_ld); end
      tests_run++; if (obs_req_cnt !== 1 || obs_stall_cnt !== 2) begin tests_failed++; $display("FAIL sh_timing: got req=%0d stall=%0d want 1/2", obs_req_cnt, obs_stall_cnt); end
   endtask

   task automatic test_fault();
      run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h12345678, 2);
      $display("[TB] txn LW addr=00000101 misaligned");
      tests_run++; if (obs_fault0 !== 1'b1) begin tests_failed++; $display("FAIL fault_lw: got %b want 1", obs_fault0); end
      tests_run++; if (obs_req_cnt !== 0 || obs_stall_cnt !== 0 || obs_lv_cnt !== 0) begin tests_failed++; $display("FAIL fault_lw_quiet: got req=%0d stall=%0d lv=%0d want 0/0/0", obs_req_cnt, obs_stall_cnt, obs_lv_cnt); end
      tests_run++; if (obs_ld !== model_ld) begin tests_failed++; $display("FAIL fault_lw_data: got %h want %h", obs_ld, model_ld); end
      run_access(1'b0, 1'b1, 3'b011, 32'h200, 32'h55, 0, 32'h0, 2);
      $display("[TB] txn store f3=011 illegal");
      tests_run++; if (obs_fault0 !== 1'b1) begin tests_failed++; $display("FAIL fault_st011: got %b want 1", obs_fault0); end
      tests_run++; if (obs_req_cnt !== 0 || obs_stall_cnt !== 0) begin tests_failed++; $display("FAIL fault_st011_quiet: got req=%0d stall=%0d want 0/0", obs_req_cnt, obs_stall_cnt); end
   endtask

   task automatic test_timeout();
      logic [31:0] r;
      run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, -1, 32'hCAFEF00D, TO + 2);
      $display("[TB] txn LW addr=00000300 no ready");
      tests_run++; if (obs_be_cnt !== 1 || obs_be_cycle !== TO + 1) begin tests_failed++; $display("FAIL timeout_pulse: got %0d pulses at %0d want 1 at %0d", obs_be_cnt, obs_be_cycle, TO + 1); end
      tests_run++; if (obs_req_cnt !== TO || obs_stall_cnt !== TO + 1) begin tests_failed++; $display("FAIL timeout_req_stall: got %0d/%0d want %0d/%0d", obs_req_cnt, obs_stall_cnt, TO, TO + 1); end
      tests_run++; if (obs_ld !== model_ld) begin tests_failed++; $display("FAIL timeout_data: got %h want %h", obs_ld, model_ld); end

      // second access interrupted by reset mid-BUSY
      r = $urandom;
      @(negedge clock);
      M_mem_read_in = 1'b1; funct3_in = 3'b010; ALU_result_in = 32'h400; dmem_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_req: got %b want 0", dmem_req); end
      reset = 1'b0; M_mem_read_in = 1'b0; dmem_ready = 1'b1; dmem_rdata = r;
      @(negedge clock);
      dmem_ready = 1'b0;
      #1;
      model_ld = 32'h0;
      tests_run++; if (load_valid !== 1'b0 || load_data_out !== model_ld || mem_stall !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_late_ready: got lv=%b data=%h stall=%b want 0/%h/0", load_valid, load_data_out, mem_stall, model_ld); end
      $display("[TB] txn LW addr=00000400 reset mid-busy");
   endtask

   task automatic test_branch();
      @(negedge clock);
      M_branch_in = 1'b1; ALU_zero_in = 1'b1; branch_adder_sum_in = 32'h40;
      #1;
      tests_run++; if (pc_src !== 1'b1 || branch_target_out !== 32'h40) begin tests_failed++; $display("FAIL branch_taken: got %b/%h want 1/00000040", pc_src, branch_target_out); end
      ALU_zero_in = 1'b0;
      #1;
      tests_run++; if (pc_src !== 1'b0) begin tests_failed++; $display("FAIL branch_not_taken: got %b want 0", pc_src); end
      for (int i = 0; i < 8; i++) begin
         logic b, z;
         logic [31:0] t;
         b = 1'($urandom); z = 1'($urandom); t = $urandom;
         M_branch_in = b; ALU_zero_in = z; branch_adder_sum_in = t;
         #1;
         tests_run++; if (pc_src !== (b && z) || branch_target_out !== t) begin tests_failed++; $display("FAIL branch_rand_%0d: got %b/%h want %b/%h", i, pc_src, branch_target_out, b && z, t); end
         $display("[TB] txn branch b=%b z=%b target=%h", b, z, t);
      end
      M_branch_in = 1'b0; ALU_zero_in = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         bit rd, wr, legal, st;
         logic [2:0]  f3;
         logic [31:0] a, d, rdata;
         int k, sel;
         sel = $urandom_range(0, 2);
         rd = (sel != 1); wr = (sel != 0);
         f3 = 3'($urandom_range(0, 7));
         a = 32'h1000 + {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3));
         d = $urandom; rdata = $urandom;
         k = $urandom_range(0, TO - 1);
         st = wr;
         legal = m_legal(wr, f3, a);
         run_access(rd, wr, f3, a, d, k, rdata, legal ? k + 3 : 2);
         $display("[TB] txn %0d rd=%b wr=%b f3=%b addr=%h k=%0d legal=%b", i, rd, wr, f3, a, k, legal);
         tests_run++; if (obs_fault0 !== !legal) begin tests_failed++; $display("FAIL rand_%0d_fault: got %b want %b", i, obs_fault0, !legal); end
         if (legal) begin
            tests_run++; if (obs_req_cnt !== k + 1 || obs_stall_cnt !== k + 2) begin tests_failed++; $display("FAIL rand_%0d_timing: got req=%0d stall=%0d want %0d/%0d", i, obs_req_cnt, obs_stall_cnt, k + 1, k + 2); end
            tests_run++; if (obs_addr !== {a[31:2], 2'b00} || obs_we !== st) begin tests_failed++; $display("FAIL rand_%0d_addr_we: got %h/%b want %h/%b", i, obs_addr, obs_we, {a[31:2], 2'b00}, st); end
            if (st) begin
               tests_run++; if (obs_wstrb !== m_strb(f3, a) || obs_wdata !== m_wdata(f3, d)) begin tests_failed++; $display("FAIL rand_%0d_store: got %b/%h want %b/%h", i, obs_wstrb, obs_wdata, m_strb(f3, a), m_wdata(f3, d)); end
            end else begin
               model_ld = m_load(f3, a, rdata);
               tests_run++; if (obs_wstrb !== 4'b0000 || obs_lv_cnt !== 1 || obs_lv_cycle !== k + 2) begin tests_failed++; $display("FAIL rand_%0d_load_valid: got strb=%b lv=%0d@%0d want 0000/1@%0d", i, obs_wstrb, obs_lv_cnt, obs_lv_cycle, k + 2); end
            end
         end else begin
            tests_run++; if (obs_req_cnt !== 0 || obs_stall_cnt !== 0) begin tests_failed++; $display("FAIL rand_%0d_quiet: got req=%0d stall=%0d want 0/0", i, obs_req_cnt, obs_stall_cnt); end
         end
         tests_run++; if (obs_ld !== model_ld) begin tests_failed++; $display("FAIL rand_%0d_data: got %h want %h", i, obs_ld, model_ld); end
      end
   endtask

   initial begin
      model_ld = 32'h0;
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_fault();
      test_timeout();
      test_branch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
